uart_rx: RTL and testbench

UART receiver that deserialises the `rx` line into a data word for the register block, and is the counterpart of the UART transmitter on the same link. It uses 16x oversampling from the baudrate generator (`rx_tick`) and supports 5–8 data bits LSB-first, optional odd/even parity and 1 or 2 stop bits. It reports parity, framing and overrun errors, and drives `rts_n` for hardware flow control.

---
 rtl/uart_rx_if.sv | 25 ++
 rtl/uart_rx.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx register-side bundle: frame configuration, read acknowledge,
// received data word and per-frame status flags.
// The master side is the register block, the slave side is the receiver.
interface uart_rx_if;
    logic [1:0]  data_bit_num_i;
    logic        parity_en_i;
    logic        parity_type_i;
    logic        stop_bit_num_i;
    logic        rx_ack_i;
    logic [31:0] rx_data_o;
    logic        rx_valid_o;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        overrun_o;

    modport master (
        output data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i, rx_ack_i,
        input  rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_o
    );

    modport slave (
        input  data_bit_num_i, parity_en_i, parity_type_i, stop_bit_num_i, rx_ack_i,
        output rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_o
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, 5..8 data bits LSB first,
// optional odd/even parity, 1 or 2 stop bits, parity/framing/overrun flags
// and rts_n flow control.
// Optional feature macro: UART_RX_MAJORITY_EN -- when defined, every bit is a
// 2-of-3 vote of samples at OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2;
// otherwise a single sample at OVERSAMPLE/2-1 is used.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     rx_tick,
    input  logic     rx,
    output logic     rts_n,
    uart_rx_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MAX = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] CNT_S0  = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] CNT_DEC = CW'(OVERSAMPLE / 2);
`else
    localparam logic [CW-1:0] CNT_DEC = CNT_MID;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Parity check: data XOR parity bit must be 1 for odd (type 0), 0 for even.
    function automatic logic parity_bad(input logic acc, input logic pbit, input logic ptype);
        return ((acc ^ pbit) != ~ptype);
    endfunction

`ifdef UART_RX_MAJORITY_EN
    // 2-of-3 majority vote.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    logic          rx_meta_q, rx_sync_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          par_q, par_d;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;
    logic [1:0]    dbits_q, dbits_d;
    logic          pen_q, pen_d;
    logic          ptype_q, ptype_d;
    logic          stop2_q, stop2_d;
    logic          commit_s;
    logic          bit_s;
    logic [31:0]   rx_data_q;
    logic          rx_valid_q, perr_out_q, ferr_out_q, overrun_q;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic samp0_q, samp1_q;

    // Capture the first two votes; the third is the live sample at decision time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp0_q <= 1'b1;
            samp1_q <= 1'b1;
        end else if (rx_tick && (cnt_q == CNT_S0)) begin
            samp0_q <= rx_sync_q;
        end else if (rx_tick && (cnt_q == CNT_MID)) begin
            samp1_q <= rx_sync_q;
        end else begin
            samp0_q <= samp0_q;
            samp1_q <= samp1_q;
        end
    end

    assign bit_s = maj3(samp0_q, samp1_q, rx_sync_q);
`else
    assign bit_s = rx_sync_q;
`endif

    // Frame FSM and datapath state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shreg_q <= 8'd0;
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            dbits_q <= 2'd0;
            pen_q   <= 1'b0;
            ptype_q <= 1'b0;
            stop2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            dbits_q <= dbits_d;
            pen_q   <= pen_d;
            ptype_q <= ptype_d;
            stop2_q <= stop2_d;
        end
    end

    // Next-state logic; everything advances only on rx_tick clocks.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        dbits_d  = dbits_q;
        pen_d    = pen_q;
        ptype_d  = ptype_q;
        stop2_d  = stop2_q;
        commit_s = 1'b0;
        if (rx_tick) begin
            // Free-running modulo counter keeps decisions exactly one bit apart.
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rx_sync_q) begin
                        state_d = START;
                        dbits_d = bus.data_bit_num_i;
                        pen_d   = bus.parity_en_i;
                        ptype_d = bus.parity_type_i;
                        stop2_d = bus.stop_bit_num_i;
                        idx_d   = 3'd0;
                        shreg_d = 8'd0;
                        par_d   = 1'b0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    if (cnt_q == CNT_DEC) begin
                        if (bit_s) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = START;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_DEC) begin
                        shreg_d[idx_q] = bit_s;
                        par_d          = par_q ^ bit_s;
                        // Last index is 4..7 for 5..8 data bits.
                        if (idx_q == {1'b1, dbits_q}) begin
                            idx_d   = 3'd0;
                            state_d = pen_q ? PARITY : STOP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
                PARITY: begin
                    if (cnt_q == CNT_DEC) begin
                        perr_d  = parity_bad(par_q, bit_s, ptype_q);
                        idx_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        state_d = PARITY;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_DEC) begin
                        ferr_d = ferr_q | ~bit_s;
                        // Commit at mid of the last stop bit to resync early.
                        if (idx_q[0] == stop2_q) begin
                            commit_s = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        state_d = STOP;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output holding register: commit wins over a same-cycle acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_q  <= 32'd0;
            rx_valid_q <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (commit_s) begin
            rx_data_q  <= {24'd0, shreg_q};
            rx_valid_q <= 1'b1;
            perr_out_q <= perr_q;
            ferr_out_q <= ferr_d;
            if (rx_valid_q && !bus.rx_ack_i) begin
                overrun_q <= 1'b1;
            end else if (rx_valid_q && bus.rx_ack_i) begin
                overrun_q <= 1'b0;
            end else begin
                overrun_q <= overrun_q;
            end
        end else if (bus.rx_ack_i && rx_valid_q) begin
            rx_valid_q <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_q;
            rx_valid_q <= rx_valid_q;
            perr_out_q <= perr_out_q;
            ferr_out_q <= ferr_out_q;
            overrun_q  <= overrun_q;
        end
    end

    assign bus.rx_data_o    = rx_data_q;
    assign bus.rx_valid_o   = rx_valid_q;
    assign bus.parity_err_o = perr_out_q;
    assign bus.frame_err_o  = ferr_out_q;
    assign bus.overrun_o    = overrun_q;
    assign rts_n            = rx_valid_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 4 clocks per rx_tick, 64 clocks per bit.
module tb_uart_rx;
    logic clk;
    logic rst_n;
    logic rx_tick;
    logic rx;
    logic rts_n;
    int   total;
    int   bad;

    uart_rx_if bus();

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_tick (rx_tick),
        .rx      (rx),
        .rts_n   (rts_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rx_tick: one clock high every four clocks
    initial begin
        rx_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            rx_tick = 1'b1;
            @(negedge clk);
            rx_tick = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bit_time();
        repeat (64) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input int nb, input bit pen, input bit pbit,
                        input int nstop, input bit stop2v);
        rx = 1'b0;
        bit_time();
        for (int i = 0; i < nb; i++) begin
            rx = d[i];
            bit_time();
        end
        if (pen) begin
            rx = pbit;
            bit_time();
        end
        rx = 1'b1;
        bit_time();
        if (nstop == 2) begin
            rx = stop2v;
            bit_time();
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (bus.rx_valid_o === 1'b1) break;
            @(negedge clk);
        end
        check(tag, {31'd0, bus.rx_valid_o}, 32'd1);
    endtask

    task automatic ack();
        @(negedge clk);
        bus.rx_ack_i = 1'b1;
        @(negedge clk);
        bus.rx_ack_i = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] nb, input logic pen, input logic pt, input logic sb);
        bus.data_bit_num_i = nb;
        bus.parity_en_i    = pen;
        bus.parity_type_i  = pt;
        bus.stop_bit_num_i = sb;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        rx    = 1'b1;
        bus.rx_ack_i = 1'b0;
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);

        // reset values
        check("rst_data",  bus.rx_data_o, 32'd0);
        check("rst_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        check("rst_perr",  {31'd0, bus.parity_err_o}, 32'd0);
        check("rst_ferr",  {31'd0, bus.frame_err_o}, 32'd0);
        check("rst_ovr",   {31'd0, bus.overrun_o}, 32'd0);
        check("rst_rts",   {31'd0, rts_n}, 32'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        // 8N1 0xA5
        send(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_valid("a5_valid");
        check("a5_data", bus.rx_data_o, 32'h0000_00A5);
        check("a5_perr", {31'd0, bus.parity_err_o}, 32'd0);
        check("a5_ferr", {31'd0, bus.frame_err_o}, 32'd0);
        check("a5_ovr",  {31'd0, bus.overrun_o}, 32'd0);
        check("a5_rts",  {31'd0, rts_n}, 32'd1);
        ack();
        check("a5_ack_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        check("a5_ack_rts",   {31'd0, rts_n}, 32'd0);
        check("a5_ack_data",  bus.rx_data_o, 32'h0000_00A5);
        ack();
        check("idle_ack_data", bus.rx_data_o, 32'h0000_00A5);

        // 7O1 0x35: good parity then bad parity
        cfg(2'b10, 1'b1, 1'b0, 1'b0);
        send(8'h35, 7, 1'b1, 1'b1, 1, 1'b1);
        wait_valid("o1_valid");
        check("o1_data", bus.rx_data_o, 32'h0000_0035);
        check("o1_perr", {31'd0, bus.parity_err_o}, 32'd0);
        ack();
        send(8'h35, 7, 1'b1, 1'b0, 1, 1'b1);
        wait_valid("o1b_valid");
        check("o1b_data", bus.rx_data_o, 32'h0000_0035);
        check("o1b_perr", {31'd0, bus.parity_err_o}, 32'd1);
        ack();
        check("o1b_ack_perr", {31'd0, bus.parity_err_o}, 32'd0);

        // 5E2 0x1F, second stop bit low
        cfg(2'b00, 1'b1, 1'b1, 1'b1);
        send(8'h1F, 5, 1'b1, 1'b1, 2, 1'b0);
        wait_valid("e2_valid");
        check("e2_data", bus.rx_data_o, 32'h0000_001F);
        check("e2_ferr", {31'd0, bus.frame_err_o}, 32'd1);
        check("e2_perr", {31'd0, bus.parity_err_o}, 32'd0);
        ack();
        check("e2_ack_ferr", {31'd0, bus.frame_err_o}, 32'd0);
        bit_time();
        bit_time();
        check("e2_no_extra", {31'd0, bus.rx_valid_o}, 32'd0);

        // glitch of 4 ticks, then a real 8N1 frame
        cfg(2'b11, 1'b0, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        bit_time();
        bit_time();
        check("glitch_no_commit", {31'd0, bus.rx_valid_o}, 32'd0);
        send(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_valid("3c_valid");
        check("3c_data", bus.rx_data_o, 32'h0000_003C);
        check("3c_perr", {31'd0, bus.parity_err_o}, 32'd0);
        check("3c_ferr", {31'd0, bus.frame_err_o}, 32'd0);
        ack();

        // overrun
        send(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_valid("ovr1_valid");
        check("ovr1_ovr", {31'd0, bus.overrun_o}, 32'd0);
        send(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
        check("ovr2_data",  bus.rx_data_o, 32'h0000_0022);
        check("ovr2_ovr",   {31'd0, bus.overrun_o}, 32'd1);
        check("ovr2_valid", {31'd0, bus.rx_valid_o}, 32'd1);
        ack();
        check("ovr_ack_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        check("ovr_ack_ovr",   {31'd0, bus.overrun_o}, 32'd0);

        // reset during data bit 3, with an unread frame held
        send(8'h5A, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_valid("pre_rst_valid");
        rx = 1'b0;
        bit_time();
        rx = 1'b1; bit_time();
        rx = 1'b0; bit_time();
        rx = 1'b0; bit_time();
        rx = 1'b0;
        repeat (32) @(negedge clk);
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) @(negedge clk);
        check("mrst_data",  bus.rx_data_o, 32'd0);
        check("mrst_valid", {31'd0, bus.rx_valid_o}, 32'd0);
        check("mrst_ferr",  {31'd0, bus.frame_err_o}, 32'd0);
        check("mrst_ovr",   {31'd0, bus.overrun_o}, 32'd0);
        check("mrst_rts",   {31'd0, rts_n}, 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        bit_time();
        bit_time();
        check("post_rst_idle", {31'd0, bus.rx_valid_o}, 32'd0);
        send(8'h81, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_valid("81_valid");
        check("81_data", bus.rx_data_o, 32'h0000_0081);
        check("81_ferr", {31'd0, bus.frame_err_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
